// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM state type, BHT counter constants and saturating update
package branch_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} br_state_e;

    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MAX  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == CTR_MAX) ? ctr : ctr + 2'd1)
                     : ((ctr == 2'd0) ? ctr : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// bht_2bit: array of 2-bit saturating counters, combinational read, read-modify-write update
module bht_2bit
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] r_ctr [DEPTH];

    assign rd_msb = r_ctr[rd_idx][1];

    // counters start weakly not-taken and step toward the resolved outcome
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
        end else if (we) begin
            r_ctr[wr_idx] <= sat_update(r_ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch/jump/halt resolver with BHT prediction, redirect and flush
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W         = 9,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            ex_halt,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    output logic [31:0]     pc_imm,
    output logic [31:0]     pc_four,
    output logic [31:0]     br_pc,
    output logic            pc_sel,
    output logic            flush,
    output logic            halted,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FC_W  = (FLUSH_STAGES > 1) ? $clog2(FLUSH_STAGES) : 1;

    br_state_e   r_state, w_state_n;
    logic [FC_W-1:0] r_fcnt, w_fcnt_n;
    logic [31:0] r_br_pc, w_br_pc_n, r_cnt, w_cnt_n;
    logic        r_sel, w_sel_n, r_flush, w_flush_n, r_halted, w_halted_n;
    logic [31:0] w_pc_full, w_target;
    logic        w_accept, w_is_br, w_cond, w_mis, w_jump, w_redirect;

    assign w_pc_full  = 32'(ex_pc);
    assign pc_imm     = ex_jalr ? {ex_alu_result[31:1], 1'b0} : w_pc_full + ex_imm;
    assign pc_four    = (r_state == HALTED) ? 32'd0 : w_pc_full + 32'd4;
    assign w_accept   = ex_valid && (r_state == RUN);
    assign w_is_br    = ex_branch & ~ex_jal & ~ex_jalr & ~ex_halt;
    assign w_cond     = ex_branch & ex_alu_result[0];
    assign w_mis      = w_is_br & (w_cond != ex_pred_taken);
    assign w_jump     = ex_jal | ex_jalr;
    assign w_redirect = w_accept & ~ex_halt & (w_jump | w_mis);
    assign w_target   = (w_jump | w_cond) ? pc_imm : pc_four;

    assign br_pc          = r_br_pc;
    assign pc_sel         = r_sel;
    assign flush          = r_flush;
    assign halted         = r_halted;
    assign mispredict_cnt = r_cnt;

    bht_2bit #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (IDX_W'(32'(if_pc) >> 2)),
        .rd_msb   (if_pred_taken),
        .we       (w_accept & w_is_br),
        .wr_idx   (IDX_W'(w_pc_full >> 2)),
        .wr_taken (w_cond)
    );

    // next state: halted holds everything, flush counts down, run resolves the EX instruction
    always_comb begin
        w_state_n  = r_state;
        w_fcnt_n   = r_fcnt;
        w_br_pc_n  = r_br_pc;
        w_sel_n    = 1'b0;
        w_flush_n  = 1'b0;
        w_halted_n = 1'b0;
        w_cnt_n    = (w_accept && w_mis) ? r_cnt + 32'd1 : r_cnt;
        if (r_state == HALTED) begin
            w_sel_n    = 1'b1;
            w_flush_n  = 1'b1;
            w_halted_n = 1'b1;
        end else if (r_state == FLUSH) begin
            w_state_n = (r_fcnt == '0) ? RUN : FLUSH;
            w_flush_n = (r_fcnt != '0);
            w_fcnt_n  = (r_fcnt == '0) ? r_fcnt : r_fcnt - FC_W'(1);
        end else if (w_accept && ex_halt) begin
            w_state_n  = HALTED;
            w_br_pc_n  = w_pc_full;
            w_sel_n    = 1'b1;
            w_flush_n  = 1'b1;
            w_halted_n = 1'b1;
        end else if (w_redirect) begin
            w_state_n = (FLUSH_STAGES > 1) ? FLUSH : RUN;
            w_fcnt_n  = FC_W'(FLUSH_STAGES - 1);
            w_br_pc_n = w_target;
            w_sel_n   = 1'b1;
            w_flush_n = 1'b1;
        end
    end

    // state, redirect outputs and mispredict statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_fcnt   <= '0;
            r_br_pc  <= '0;
            r_sel    <= 1'b0;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_fcnt   <= w_fcnt_n;
            r_br_pc  <= w_br_pc_n;
            r_sel    <= w_sel_n;
            r_flush  <= w_flush_n;
            r_halted <= w_halted_n;
            r_cnt    <= w_cnt_n;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: table-driven and directed checks of resolution, BHT, flush and halt
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  if_pc, ex_pc;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr, ex_halt, ex_pred_taken;
    logic [31:0] ex_imm, ex_alu_result;
    logic        if_pred, pc_sel, flush, halted;
    logic [31:0] pc_imm, pc_four, br_pc, cnt;
    logic [31:0] b_if_pc, b_ex_pc;
    logic        b_ex_valid, b_if_pred, b_sel, b_flush, b_halted;
    logic [31:0] b_pc_imm, b_pc_four, b_br_pc, b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(9), .BHT_DEPTH(16), .FLUSH_STAGES(2)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_halt(ex_halt), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .pc_imm(pc_imm), .pc_four(pc_four), .br_pc(br_pc),
        .pc_sel(pc_sel), .flush(flush), .halted(halted), .mispredict_cnt(cnt)
    );

    branch_predict_unit #(.PC_W(32), .BHT_DEPTH(16), .FLUSH_STAGES(2)) dut_w (
        .clk(clk), .reset(reset), .if_pc(b_if_pc), .if_pred_taken(b_if_pred),
        .ex_valid(b_ex_valid), .ex_pc(b_ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_halt(ex_halt), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .pc_imm(b_pc_imm), .pc_four(b_pc_four), .br_pc(b_br_pc),
        .pc_sel(b_sel), .flush(b_flush), .halted(b_halted), .mispredict_cnt(b_cnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc, imm;
        logic        br, jal, jalr;
        logic [31:0] alu;
        logic        pred;
        logic [31:0] e_imm, e_four;
        logic        e_sel;
        logic [31:0] e_br, e_cnt;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input logic v, input logic [31:0] pc, imm, input logic br, jal, jalr,
                                input logic [31:0] alu, input logic pred, input logic [31:0] e_imm, e_four,
                                input logic e_sel, input logic [31:0] e_br, e_cnt);
        vec_t t;
        t.v = v; t.pc = pc; t.imm = imm; t.br = br; t.jal = jal; t.jalr = jalr; t.alu = alu;
        t.pred = pred; t.e_imm = e_imm; t.e_four = e_four; t.e_sel = e_sel; t.e_br = e_br; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one accepted instruction followed by the full flush window
    task automatic exec(input vec_t t, input string name);
        ex_valid = t.v; ex_pc = t.pc[8:0]; ex_imm = t.imm; ex_branch = t.br; ex_jal = t.jal;
        ex_jalr = t.jalr; ex_halt = 1'b0; ex_alu_result = t.alu; ex_pred_taken = t.pred;
        #1;
        chk({name, "_pc_imm"}, pc_imm, t.e_imm);
        chk({name, "_pc_four"}, pc_four, t.e_four);
        tick();
        chk({name, "_sel"}, 32'(pc_sel), 32'(t.e_sel));
        chk({name, "_flush1"}, 32'(flush), 32'(t.e_sel));
        chk({name, "_cnt"}, cnt, t.e_cnt);
        if (t.e_sel) chk({name, "_br_pc"}, br_pc, t.e_br);
        ex_valid = 1'b0;
        tick();
        chk({name, "_sel_pulse"}, 32'(pc_sel), 32'd0);
        chk({name, "_flush2"}, 32'(flush), 32'(t.e_sel));
        tick();
        chk({name, "_flush_end"}, 32'(flush), 32'd0);
    endtask

    initial begin
        int bad;
        tbl[0] = mk(1, 32'h10,  32'h8,        1, 0, 0, 32'h1,   0, 32'h18,  32'h14,  1, 32'h18,  1);
        tbl[1] = mk(1, 32'h20,  32'hFFFFFFFC, 1, 0, 0, 32'h0,   1, 32'h1C,  32'h24,  1, 32'h24,  2);
        tbl[2] = mk(1, 32'h30,  32'h10,       1, 0, 0, 32'h0,   0, 32'h40,  32'h34,  0, 32'h0,   2);
        tbl[3] = mk(1, 32'h50,  32'h4,        0, 0, 1, 32'h41,  0, 32'h40,  32'h54,  1, 32'h40,  2);
        tbl[4] = mk(1, 32'h20,  32'h100,      0, 1, 0, 32'h1,   0, 32'h120, 32'h24,  1, 32'h120, 2);
        tbl[5] = mk(1, 32'h80,  32'h8,        0, 1, 1, 32'h101, 0, 32'h100, 32'h84,  1, 32'h100, 2);
        tbl[6] = mk(0, 32'h10,  32'h8,        1, 0, 0, 32'h1,   0, 32'h18,  32'h14,  0, 32'h0,   2);
        tbl[7] = mk(1, 32'h1FC, 32'h8,        1, 0, 0, 32'h1,   1, 32'h204, 32'h200, 0, 32'h0,   2);

        reset = 1'b1; if_pc = 9'h10; ex_pc = '0; ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
        ex_halt = 0; ex_pred_taken = 0; ex_imm = '0; ex_alu_result = '0;
        b_if_pc = '0; b_ex_pc = '0; b_ex_valid = 0;
        #2;
        chk("rst_br_pc", br_pc, 0);
        chk("rst_sel", 32'(pc_sel), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_pred", 32'(if_pred), 0);
        #10 reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) exec(tbl[i], $sformatf("v%0d", i));

        if_pc = 9'h10; #1 chk("bht_idx4", 32'(if_pred), 1);
        if_pc = 9'h20; #1 chk("bht_idx8", 32'(if_pred), 0);
        if_pc = 9'h3C; #1 chk("bht_idx15_alias", 32'(if_pred), 1);

        if_pc = 9'h10;
        exec(mk(1, 32'h10, 32'h8, 1, 0, 0, 32'h1, 1, 32'h18, 32'h14, 0, 32'h0, 2), "t2a");
        chk("t2a_pred", 32'(if_pred), 1);
        exec(mk(1, 32'h10, 32'h8, 1, 0, 0, 32'h1, 1, 32'h18, 32'h14, 0, 32'h0, 2), "t2b");
        chk("t2b_pred", 32'(if_pred), 1);
        exec(mk(1, 32'h10, 32'h8, 1, 0, 0, 32'h0, 1, 32'h18, 32'h14, 1, 32'h14, 3), "t2c");
        chk("t2c_pred_sat_hi", 32'(if_pred), 1);
        exec(mk(1, 32'h10, 32'h8, 1, 0, 0, 32'h0, 1, 32'h18, 32'h14, 1, 32'h14, 4), "t2d");
        chk("t2d_pred", 32'(if_pred), 0);
        if_pc = 9'h20;
        exec(mk(1, 32'h20, 32'h8, 1, 0, 0, 32'h1, 0, 32'h28, 32'h24, 1, 32'h28, 5), "t2e");
        chk("t2e_pred_sat_lo", 32'(if_pred), 0);
        exec(mk(1, 32'h20, 32'h8, 1, 0, 0, 32'h1, 0, 32'h28, 32'h24, 1, 32'h28, 6), "t2f");
        chk("t2f_pred", 32'(if_pred), 1);

        ex_valid = 1; ex_branch = 0; ex_jal = 1; ex_pc = 9'h40; ex_imm = 32'h10; ex_alu_result = 0; ex_pred_taken = 0;
        tick();
        chk("t4_sel", 32'(pc_sel), 1);
        chk("t4_br_pc", br_pc, 32'h50);
        ex_jal = 0; ex_branch = 1; ex_pc = 9'h20; ex_pred_taken = 1;
        tick();
        chk("t4_no_second_pulse", 32'(pc_sel), 0);
        chk("t4_flush_b", 32'(flush), 1);
        tick();
        ex_valid = 0;
        chk("t4_flush_end", 32'(flush), 0);
        chk("t4_cnt", cnt, 6);
        #1 chk("t4_bht_untouched", 32'(if_pred), 1);
        tick();
        chk("t4_sel_after", 32'(pc_sel), 0);

        if_pc = 9'h3C;
        ex_valid = 1; ex_branch = 0; ex_halt = 1; ex_pc = 9'h2C;
        tick();
        chk("t5_halted", 32'(halted), 1);
        chk("t5_sel", 32'(pc_sel), 1);
        chk("t5_br_pc", br_pc, 32'h2C);
        chk("t5_flush", 32'(flush), 1);
        chk("t5_pc_four", pc_four, 0);
        ex_halt = 0; ex_branch = 1; ex_pc = 9'h3C; ex_alu_result = 0; ex_pred_taken = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted !== 1 || pc_sel !== 1 || flush !== 1 || br_pc !== 32'h2C || pc_four !== 0 || cnt !== 6)
                bad++;
        end
        chk("t5_halt_hold", bad, 0);
        chk("t5_bht_frozen", 32'(if_pred), 1);
        #3 reset = 1'b1;
        #1;
        chk("t5_rst_br_pc", br_pc, 0);
        chk("t5_rst_sel", 32'(pc_sel), 0);
        chk("t5_rst_flush", 32'(flush), 0);
        chk("t5_rst_halted", 32'(halted), 0);
        chk("t5_rst_cnt", cnt, 0);
        chk("t5_rst_pred", 32'(if_pred), 0);
        chk("t5_rst_pc_four", pc_four, 32'h40);
        ex_valid = 0;
        #2 reset = 1'b0;
        tick();
        exec(mk(1, 32'h10, 32'h8, 1, 0, 0, 32'h1, 0, 32'h18, 32'h14, 1, 32'h18, 1), "t5_run");

        b_ex_valid = 1; b_ex_pc = 32'hFFFFFFFC; b_if_pc = 32'hFFFFFFFC;
        ex_branch = 1; ex_jal = 0; ex_jalr = 0; ex_halt = 0; ex_imm = 32'h8; ex_alu_result = 1; ex_pred_taken = 0;
        #1;
        chk("t6_pc_imm_wrap", b_pc_imm, 32'h4);
        chk("t6_pc_four_wrap", b_pc_four, 32'h0);
        chk("t6_pred_old", 32'(b_if_pred), 0);
        tick();
        b_ex_valid = 0;
        chk("t6_pred_new", 32'(b_if_pred), 1);
        chk("t6_sel", 32'(b_sel), 1);
        chk("t6_br_pc", b_br_pc, 32'h4);
        chk("t6_flush", 32'(b_flush), 1);
        chk("t6_cnt", b_cnt, 1);
        chk("t6_halted", 32'(b_halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
